// File: rtl/bridge_setpoint_ramp.sv
// bridge_setpoint_ramp: slew-limited signed duty setpoint with zero-crossing hold.
// Optional: BRIDGE_RAMP_FAULT_LATCH_EN latches FAULT until i_fault_clr.
module bridge_setpoint_ramp #(
  parameter int STEP      = 8,
  parameter int RATE_DIV  = 1000,
  parameter int ZERO_HOLD = 5000,
  parameter int LIMIT     = 1023
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cmd_valid,
  input  logic [10:0] i_cmd_target,
  output logic        o_cmd_ready,
  input  logic        i_fault,
  input  logic        i_fault_clr,
  output logic [10:0] o_signed_val,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fault
);

  localparam int CW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam int HW = $clog2(ZERO_HOLD + 1);

  localparam logic signed [11:0] STEP_S = 12'(STEP);
  localparam logic signed [11:0] LIM_S  = 12'(LIMIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(RATE_DIV - 1);
  localparam logic [HW-1:0] HOLD_LD = HW'(ZERO_HOLD);
  localparam logic [HW-1:0] HOLD_END = HW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAMP,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t r_state, w_state_nx;

  logic [10:0]   r_val, w_val_nx;
  logic [10:0]   r_tgt, w_tgt_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [HW-1:0] r_hold, w_hold_nx;
  logic          r_ready;
  logic          r_done, w_done_nx;

  logic w_accept;
  logic w_tick;
  logic w_cross;
  logic w_fault_exit;

  logic signed [11:0] w_cmd;
  logic signed [11:0] w_clamp;
  logic signed [11:0] w_cur;
  logic signed [11:0] w_tgt;
  logic signed [11:0] w_diff;
  logic signed [11:0] w_mag;
  logic signed [11:0] w_d;
  logic signed [11:0] w_step;

`ifdef BRIDGE_RAMP_FAULT_LATCH_EN
  assign w_fault_exit = i_fault_clr;
`else
  logic w_unused_clr;
  assign w_unused_clr = i_fault_clr;
  assign w_fault_exit = 1'b1;
`endif

  assign w_accept = i_cmd_valid & r_ready;
  assign w_tick   = (r_cnt == CNT_MAX);

  assign w_cmd = {i_cmd_target[10], i_cmd_target};
  assign w_clamp = (w_cmd > LIM_S)  ? LIM_S  :
                   (w_cmd < -LIM_S) ? -LIM_S : w_cmd;

  assign w_cur = {r_val[10], r_val};
  assign w_tgt = {r_tgt[10], r_tgt};

  // A reversal first drives toward zero; otherwise head straight for target.
  assign w_cross = (r_val != '0) && (r_tgt != '0) &&
                   (r_val[10] != r_tgt[10]);
  assign w_diff = w_cross ? -w_cur : (w_tgt - w_cur);
  assign w_mag  = w_diff[11] ? -w_diff : w_diff;
  assign w_d    = (w_mag < STEP_S) ? w_mag : STEP_S;
  assign w_step = w_diff[11] ? (w_cur - w_d) : (w_cur + w_d);

  always_comb begin
    w_state_nx = r_state;
    w_val_nx   = r_val;
    w_tgt_nx   = r_tgt;
    w_cnt_nx   = r_cnt;
    w_hold_nx  = r_hold;
    w_done_nx  = 1'b0;
    if (i_fault) begin
      w_state_nx = S_FAULT;
      w_val_nx   = '0;
      w_tgt_nx   = '0;
      w_cnt_nx   = '0;
      w_hold_nx  = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_tgt_nx = w_clamp[10:0];
            w_cnt_nx = '0;
            if (w_clamp == w_cur) w_done_nx = 1'b1;
            else w_state_nx = S_RAMP;
          end
        end
        S_RAMP: begin
          if (w_accept) begin
            w_tgt_nx = w_clamp[10:0];
            w_cnt_nx = '0;
          end else if (w_tick) begin
            w_cnt_nx = '0;
            w_val_nx = w_step[10:0];
            if (w_cross && (w_step == 12'sd0)) begin
              w_state_nx = S_HOLD;
              w_hold_nx  = HOLD_LD;
            end else if (!w_cross && (w_step == w_tgt)) begin
              w_state_nx = S_IDLE;
              w_done_nx  = 1'b1;
            end
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
        S_HOLD: begin
          if (w_accept) begin
            w_tgt_nx = w_clamp[10:0];
            w_cnt_nx = '0;
          end
          if (r_hold == HOLD_END) begin
            w_state_nx = S_RAMP;
            w_hold_nx  = '0;
            w_cnt_nx   = '0;
          end else begin
            w_hold_nx = r_hold - HW'(1);
          end
        end
        S_FAULT: begin
          if (w_fault_exit) w_state_nx = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_val   <= '0;
      r_tgt   <= '0;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_val   <= w_val_nx;
      r_tgt   <= w_tgt_nx;
      r_cnt   <= w_cnt_nx;
      r_hold  <= w_hold_nx;
      r_ready <= (w_state_nx != S_FAULT);
      r_done  <= w_done_nx;
    end
  end

  assign o_cmd_ready  = r_ready;
  assign o_signed_val = r_val;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = r_done;
  assign o_fault      = (r_state == S_FAULT);

endmodule
